mra_multi_dispatcher: RTL

- Multi-channel successor to the single-work-list MRA request controller.
- Accepts up to NUM_CH independent work lists (base address and item count) from the SN controller side.
- Issues line-granular memory read requests to the MRA, arbitrated round-robin across channels.
- Throttles each channel with a per-channel credit window against its downstream WI queue, and signals per-channel completion once every requested line has been popped from that queue.

---
 rtl/mra_multi_dispatcher_pkg.sv | 22 ++
 rtl/mra_multi_dispatcher_if.sv | 21 ++
 rtl/mra_multi_dispatcher_rr_arbiter.sv | 42 ++++
 rtl/mra_multi_dispatcher.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mra_multi_dispatcher_pkg.sv
// Shared types and helpers for the multi-channel MRA request dispatcher.
package mra_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } ch_state_t;

    localparam logic        MRA_RD    = 1'b0;
    localparam int unsigned MAX_LEN_W = 64;
    localparam int unsigned SUM_W     = MAX_LEN_W + 1;

    // Ceil-divide an item count by 2**shift; one spare bit absorbs the all-ones carry.
    function automatic logic [SUM_W-1:0] lines_of(input logic [MAX_LEN_W-1:0] len,
                                                  input int unsigned          shift);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, len} + ((SUM_W'(1) << shift) - SUM_W'(1));
        return sum >> shift;
    endfunction

endpackage

// File: rtl/mra_multi_dispatcher_if.sv
// Request bus between the dispatcher and the MRA.
interface mra_multi_dispatcher_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned CH_W       = 2
);
    logic                  mra_req_valid;
    logic                  mra_req_ready;
    logic [ADDR_WIDTH-1:0] mra_req_addr;
    logic [CH_W-1:0]       mra_req_ch;
    logic                  mra_rw;

    modport master (
        output mra_req_valid, mra_req_addr, mra_req_ch, mra_rw,
        input  mra_req_ready
    );

    modport slave (
        input  mra_req_valid, mra_req_addr, mra_req_ch, mra_rw,
        output mra_req_ready
    );
endinterface

// File: rtl/mra_multi_dispatcher_rr_arbiter.sv
// Round-robin arbiter; the pointer names the highest-priority requester.
module mra_rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] grant_idx_c,
    output logic          grant_vld_c
);
    logic [IW-1:0] ptr_q, ptr_d;
    int unsigned   cand;

    // Scan requesters starting at the pointer; move the pointer past an accepted winner.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_vld_c = 1'b0;
        cand        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_q) + k) % N;
            if (!grant_vld_c && req[IW'(cand)]) begin
                grant_vld_c          = 1'b1;
                grant_c[IW'(cand)]   = 1'b1;
                grant_idx_c          = IW'(cand);
            end
        end
        ptr_d = ptr_q;
        if (advance && grant_vld_c) begin
            ptr_d = IW'((32'(grant_idx_c) + 1) % N);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/mra_multi_dispatcher.sv
// Multi-channel MRA line-read dispatcher with per-channel credit windows.
module mra_multi_dispatcher
    import mra_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned LEN_WIDTH      = 32,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned QUEUE_DEPTH    = 20,
    parameter int unsigned LINE_BYTES     = 64,
    parameter int unsigned ITEMS_PER_LINE = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            start,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] wl_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]  wl_len,
    input  logic                         abort,
    mra_multi_dispatcher_if.master       mra,
    input  logic [NUM_CH-1:0]            fifo_pop,
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH-1:0]            done,
    output logic [NUM_CH-1:0]            pop_err
);
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W     = LEN_WIDTH + 1;
    localparam int unsigned IPL_SHIFT = $clog2(ITEMS_PER_LINE);

    logic [NUM_CH-1:0]     elig_c;
    logic [NUM_CH-1:0]     grant_c;
    logic [CH_W-1:0]       grant_idx_c;
    logic                  grant_vld_c;
    logic                  grant_en_c;
    logic [ADDR_WIDTH-1:0] ch_addr_c [NUM_CH];

    logic                  out_vld_q, out_vld_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;

    // Grant only into an empty or draining output stage, never while flushing.
    assign grant_en_c = !abort && (!out_vld_q || mra.mra_req_ready);

    mra_rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (elig_c),
        .advance     (grant_en_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .grant_vld_c (grant_vld_c)
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_t             state_q, state_d;
        logic [ADDR_WIDTH-1:0] addr_q, addr_d;
        logic [CNT_W-1:0]      req_rem_q, req_rem_d;
        logic [CNT_W-1:0]      pop_rem_q, pop_rem_d;
        logic                  done_q, done_d;
        logic                  err_q, err_d;
        logic                  busy_q;
        logic [CNT_W-1:0]      lines_c;
        logic                  gnt_c;
        logic                  pop_ok_c;

        assign lines_c  = CNT_W'(lines_of(MAX_LEN_W'(wl_len[g*LEN_WIDTH +: LEN_WIDTH]), IPL_SHIFT));
        assign gnt_c    = grant_c[g] && grant_en_c;
        assign pop_ok_c = fifo_pop[g] && (state_q != IDLE) && (pop_rem_q != '0);
        // Outstanding lines (granted but not popped) must stay below the queue depth.
        assign elig_c[g] = (state_q == REQ) && (req_rem_q != '0)
                        && ((pop_rem_q - req_rem_q) < CNT_W'(QUEUE_DEPTH));
        assign ch_addr_c[g] = addr_q;
        assign busy[g]      = busy_q;
        assign done[g]      = done_q;
        assign pop_err[g]   = err_q;

        // Channel next-state: start, grant/pop bookkeeping, completion, flush.
        always_comb begin
            state_d   = state_q;
            addr_d    = addr_q;
            req_rem_d = req_rem_q;
            pop_rem_d = pop_rem_q;
            done_d    = 1'b0;
            err_d     = fifo_pop[g] && !pop_ok_c;
            if (abort) begin
                state_d   = IDLE;
                req_rem_d = '0;
                pop_rem_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start[g]) begin
                            if (lines_c != '0) begin
                                state_d   = REQ;
                                addr_d    = wl_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
                                req_rem_d = lines_c;
                                pop_rem_d = lines_c;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        if (gnt_c) begin
                            req_rem_d = req_rem_q - CNT_W'(1);
                            addr_d    = addr_q + ADDR_WIDTH'(LINE_BYTES);
                        end
                        if (pop_ok_c) pop_rem_d = pop_rem_q - CNT_W'(1);
                        if (req_rem_d == '0) state_d = DRAIN;
                    end
                    DRAIN: begin
                        if (pop_ok_c) pop_rem_d = pop_rem_q - CNT_W'(1);
                        if (pop_rem_d == '0) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Channel registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= IDLE;
                addr_q    <= '0;
                req_rem_q <= '0;
                pop_rem_q <= '0;
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                addr_q    <= addr_d;
                req_rem_q <= req_rem_d;
                pop_rem_q <= pop_rem_d;
                done_q    <= done_d;
                err_q     <= err_d;
                busy_q    <= (state_d != IDLE);
            end
        end
    end

    // Single-entry output stage; holds until accepted, cleared by a flush.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_addr_d = out_addr_q;
        out_ch_d   = out_ch_q;
        if (abort) begin
            out_vld_d = 1'b0;
        end else if (grant_vld_c && grant_en_c) begin
            out_vld_d  = 1'b1;
            out_addr_d = ch_addr_c[grant_idx_c];
            out_ch_d   = grant_idx_c;
        end else if (mra.mra_req_ready) begin
            out_vld_d = 1'b0;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_addr_q <= '0;
            out_ch_q   <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_addr_q <= out_addr_d;
            out_ch_q   <= out_ch_d;
        end
    end

    assign mra.mra_req_valid = out_vld_q;
    assign mra.mra_req_addr  = out_addr_q;
    assign mra.mra_req_ch    = out_ch_q;
    assign mra.mra_rw        = MRA_RD;
endmodule
